rv32v_mem_sequencer: RTL and testbench

Parametrised successor to the rv32v lane-serial memory path. Latches one vector memory micro-op covering `NUM_LANES` elements, generates per-lane addresses for unit-stride, strided and indexed modes, and issues one load/store at a time to the load/store controller (LSC). Load data is returned to the lane datapath with per-lane valid strobes. Sits between the vector issue/execute stage and the scalar LSC.

---
 rtl/rv32v_mem_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_rv32v_mem_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32v_mem_sequencer.sv
// Vector memory micro-op sequencer: serialises NUM_LANES element accesses onto a scalar LSC port.
// Optional build macro RV32V_MEM_COALESCE_EN merges same-word unit-stride 8b/16b lanes into one access.
module rv32v_mem_sequencer #(
  parameter int NUM_LANES = 4,
  parameter int UOP_W     = 5,
  localparam int LW       = $clog2(NUM_LANES)
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      start,
  input  logic                      is_store,
  input  logic [1:0]                mode,
  input  logic [UOP_W-1:0]          uop_num,
  input  logic [31:0]               base,
  input  logic [31:0]               stride,
  input  logic [1:0]                veew,
  input  logic [NUM_LANES-1:0]      lane_mask,
  input  logic [NUM_LANES*32-1:0]   lane_index,
  input  logic [NUM_LANES*32-1:0]   lane_wdata,
  input  logic                      lsc_ready,
  input  logic [31:0]               lsc_rdata,
  output logic                      lsc_ren,
  output logic                      lsc_wen,
  output logic [31:0]               lsc_addr,
  output logic [3:0]                lsc_byte_en,
  output logic [31:0]               lsc_wdata,
  output logic [LW-1:0]             cur_lane,
  output logic [NUM_LANES-1:0]      ld_valid,
  output logic [NUM_LANES*32-1:0]   ld_data,
  output logic                      busy,
  output logic                      done,
  output logic                      misalign
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // The reserved width code 11 is handled as 32-bit.
  function automatic logic [1:0] ew_eff(input logic [1:0] ew);
    return (ew == 2'b11) ? 2'b10 : ew;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] ew, input logic [1:0] a);
    case (ew_eff(ew))
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return |a;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] ew, input logic [1:0] a);
    case (ew_eff(ew))
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] rep_data(input logic [1:0] ew, input logic [31:0] d);
    case (ew_eff(ew))
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] be_expand(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] ld_extract(input logic [1:0] ew, input logic [1:0] a,
                                             input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {a, 3'b000};
    case (ew_eff(ew))
      2'b00:   return {24'h000000, sh[7:0]};
      2'b01:   return {16'h0000, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] lane_addr(input logic [1:0] md, input logic [31:0] b,
                                            input logic [31:0] st, input logic [31:0] idx,
                                            input logic [31:0] e, input logic [1:0] ew);
    case (md)
      2'b01:   return b + e * st;
      2'b10:   return b + idx;
      default: return b + (e << ew_eff(ew));
    endcase
  endfunction

  state_t                    state_q;
  logic                      store_q;
  logic [1:0]                mode_q;
  logic [UOP_W-1:0]          uop_q;
  logic [31:0]               base_q;
  logic [31:0]               stride_q;
  logic [1:0]                veew_q;
  logic [NUM_LANES*32-1:0]   index_q;
  logic [NUM_LANES*32-1:0]   wdata_q;
  logic [NUM_LANES-1:0]      pending_q;
  logic [NUM_LANES-1:0]      group_q;
  logic [LW-1:0]             lane_q;
  logic                      ren_q;
  logic                      wen_q;
  logic [31:0]               addr_q;
  logic [3:0]                be_q;
  logic [31:0]               lwdata_q;
  logic [NUM_LANES-1:0]      ld_valid_q;
  logic [NUM_LANES*32-1:0]   ld_data_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      misalign_q;

  logic                      idle_s;
  logic                      c_store_s;
  logic [1:0]                c_mode_s;
  logic [UOP_W-1:0]          c_uop_s;
  logic [31:0]               c_base_s;
  logic [31:0]               c_stride_s;
  logic [1:0]                c_veew_s;
  logic [NUM_LANES*32-1:0]   c_index_s;
  logic [NUM_LANES*32-1:0]   c_wdata_s;
  logic [31:0]               addr_s [NUM_LANES];
  logic [NUM_LANES-1:0]      mis_s;
  logic [NUM_LANES-1:0]      rem_s;
  logic [LW-1:0]             first_s;
  logic                      any_s;
  logic [NUM_LANES-1:0]      group_s;
  logic [3:0]                be_lane_s [NUM_LANES];
  logic [3:0]                be_s;
  logic [31:0]               wd_s;
  logic                      chain_s;

  // While idle the lane addresses are evaluated on the incoming micro-op, afterwards on the latched copy.
  always_comb begin
    idle_s     = (state_q == ST_IDLE);
    c_store_s  = idle_s ? is_store   : store_q;
    c_mode_s   = idle_s ? mode       : mode_q;
    c_uop_s    = idle_s ? uop_num    : uop_q;
    c_base_s   = idle_s ? base       : base_q;
    c_stride_s = idle_s ? stride     : stride_q;
    c_veew_s   = idle_s ? veew       : veew_q;
    c_index_s  = idle_s ? lane_index : index_q;
    c_wdata_s  = idle_s ? lane_wdata : wdata_q;
  end

  // Per-lane addresses, the set of lanes still to service and the next access group.
  always_comb begin
    mis_s   = {NUM_LANES{1'b0}};
    first_s = {LW{1'b0}};
    any_s   = 1'b0;
    group_s = {NUM_LANES{1'b0}};
    be_s    = 4'b0000;
    wd_s    = 32'h0000_0000;
    chain_s = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      addr_s[l] = lane_addr(c_mode_s, c_base_s, c_stride_s, c_index_s[l*32 +: 32],
                            (32'(c_uop_s) << LW) | 32'(l), c_veew_s);
      mis_s[l]  = is_misaligned(c_veew_s, addr_s[l][1:0]);
    end
    // Misaligned active lanes never enter the pending set, so they are skipped without an access.
    if (idle_s) begin
      rem_s = lane_mask & ~mis_s;
    end else begin
      rem_s = pending_q & ~group_q;
    end
    for (int l = NUM_LANES - 1; l >= 0; l--) begin
      if (rem_s[l]) begin
        first_s = LW'(l);
        any_s   = 1'b1;
      end else begin
        any_s   = any_s;
      end
    end
    if (any_s) begin
      group_s[first_s] = 1'b1;
    end else begin
      group_s = {NUM_LANES{1'b0}};
    end
`ifdef RV32V_MEM_COALESCE_EN
    chain_s = any_s && (c_mode_s != 2'b01) && (c_mode_s != 2'b10) && (ew_eff(c_veew_s) != 2'b10);
    for (int l = 0; l < NUM_LANES; l++) begin
      if (LW'(l) > first_s) begin
        chain_s    = chain_s && rem_s[l] && (addr_s[l][31:2] == addr_s[first_s][31:2]);
        group_s[l] = chain_s;
      end else begin
        chain_s    = chain_s;
      end
    end
`endif
    for (int l = 0; l < NUM_LANES; l++) begin
      be_lane_s[l] = byte_en(c_veew_s, addr_s[l][1:0]);
      if (group_s[l]) begin
        be_s = be_s | be_lane_s[l];
        wd_s = wd_s | (rep_data(c_veew_s, c_wdata_s[l*32 +: 32]) & be_expand(be_lane_s[l]));
      end else begin
        be_s = be_s;
      end
    end
  end

  // Sequencer FSM with all LSC request and status outputs held in registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      store_q    <= 1'b0;
      mode_q     <= 2'b00;
      uop_q      <= {UOP_W{1'b0}};
      base_q     <= 32'h0000_0000;
      stride_q   <= 32'h0000_0000;
      veew_q     <= 2'b00;
      index_q    <= {NUM_LANES*32{1'b0}};
      wdata_q    <= {NUM_LANES*32{1'b0}};
      pending_q  <= {NUM_LANES{1'b0}};
      group_q    <= {NUM_LANES{1'b0}};
      lane_q     <= {LW{1'b0}};
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= 32'h0000_0000;
      be_q       <= 4'b0000;
      lwdata_q   <= 32'h0000_0000;
      ld_valid_q <= {NUM_LANES{1'b0}};
      ld_data_q  <= {NUM_LANES*32{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      ld_valid_q <= {NUM_LANES{1'b0}};
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            store_q    <= is_store;
            mode_q     <= mode;
            uop_q      <= uop_num;
            base_q     <= base;
            stride_q   <= stride;
            veew_q     <= veew;
            index_q    <= lane_index;
            wdata_q    <= lane_wdata;
            pending_q  <= rem_s;
            misalign_q <= |(lane_mask & mis_s);
            busy_q     <= 1'b1;
            if (any_s) begin
              state_q  <= ST_ISSUE;
              ren_q    <= ~is_store;
              wen_q    <= is_store;
              addr_q   <= {addr_s[first_s][31:2], 2'b00};
              be_q     <= be_s;
              lwdata_q <= wd_s;
              group_q  <= group_s;
              lane_q   <= first_s;
            end else begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              group_q  <= {NUM_LANES{1'b0}};
            end
          end
        end
        ST_ISSUE: begin
          if (lsc_ready) begin
            for (int l = 0; l < NUM_LANES; l++) begin
              if (group_q[l] && !store_q) begin
                ld_data_q[l*32 +: 32] <= ld_extract(veew_q, addr_s[l][1:0], lsc_rdata);
              end
            end
            ld_valid_q <= store_q ? {NUM_LANES{1'b0}} : group_q;
            pending_q  <= rem_s;
            if (any_s) begin
              addr_q   <= {addr_s[first_s][31:2], 2'b00};
              be_q     <= be_s;
              lwdata_q <= wd_s;
              group_q  <= group_s;
              lane_q   <= first_s;
            end else begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              ren_q    <= 1'b0;
              wen_q    <= 1'b0;
              addr_q   <= 32'h0000_0000;
              be_q     <= 4'b0000;
              lwdata_q <= 32'h0000_0000;
              group_q  <= {NUM_LANES{1'b0}};
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ren_q   <= 1'b0;
          wen_q   <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign lsc_ren     = ren_q;
  assign lsc_wen     = wen_q;
  assign lsc_addr    = addr_q;
  assign lsc_byte_en = be_q;
  assign lsc_wdata   = lwdata_q;
  assign cur_lane    = lane_q;
  assign ld_valid    = ld_valid_q;
  assign ld_data     = ld_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_rv32v_mem_sequencer.sv
// Scoreboard bench for rv32v_mem_sequencer: directed micro-ops, expected LSC requests and load returns queued.
module tb_rv32v_mem_sequencer;

  localparam int NL = 4;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  lane;
  } req_t;

  typedef struct packed {
    logic [3:0]   vmask;
    logic [127:0] data;
  } ld_t;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          start;
  logic          is_store;
  logic [1:0]    mode;
  logic [4:0]    uop_num;
  logic [31:0]   base;
  logic [31:0]   stride;
  logic [1:0]    veew;
  logic [3:0]    lane_mask;
  logic [127:0]  lane_index;
  logic [127:0]  lane_wdata;
  logic          lsc_ready;
  logic [31:0]   lsc_rdata;
  logic          lsc_ren;
  logic          lsc_wen;
  logic [31:0]   lsc_addr;
  logic [3:0]    lsc_byte_en;
  logic [31:0]   lsc_wdata;
  logic [1:0]    cur_lane;
  logic [3:0]    ld_valid;
  logic [127:0]  ld_data;
  logic          busy;
  logic          done;
  logic          misalign;

  int   checks = 0;
  int   errors = 0;
  req_t req_q[$];
  ld_t  ld_q[$];
  req_t mon_req;
  req_t mon_act;
  ld_t  mon_ld;
  logic [127:0] mon_data;

  rv32v_mem_sequencer #(.NUM_LANES(NL), .UOP_W(5)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .is_store(is_store), .mode(mode),
    .uop_num(uop_num), .base(base), .stride(stride), .veew(veew),
    .lane_mask(lane_mask), .lane_index(lane_index), .lane_wdata(lane_wdata),
    .lsc_ready(lsc_ready), .lsc_rdata(lsc_rdata), .lsc_ren(lsc_ren), .lsc_wen(lsc_wen),
    .lsc_addr(lsc_addr), .lsc_byte_en(lsc_byte_en), .lsc_wdata(lsc_wdata),
    .cur_lane(cur_lane), .ld_valid(ld_valid), .ld_data(ld_data),
    .busy(busy), .done(done), .misalign(misalign)
  );

  always #5 CLK = ~CLK;

  // Memory model: every word reads back as C0DE in the top half and its own low address bits below.
  assign lsc_rdata = {16'hC0DE, lsc_addr[15:0]};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, input logic [1:0] lane);
    req_t r;
    r = {ren, wen, addr, be, wd, lane};
    req_q.push_back(r);
  endtask

  task automatic push_ld(input logic [3:0] vmask, input logic [127:0] data);
    ld_t e;
    e = {vmask, data};
    ld_q.push_back(e);
  endtask

  // Monitor: every accepted request and every load-return strobe is matched against the queues.
  always @(negedge CLK) begin
    if (nRST && (lsc_ren || lsc_wen) && lsc_ready) begin
      mon_act = {lsc_ren, lsc_wen, lsc_addr, lsc_byte_en, lsc_wdata, cur_lane};
      if (req_q.size() == 0) begin
        chk("req_unexpected", 128'(mon_act), 128'd0);
      end else begin
        mon_req = req_q.pop_front();
        chk("req", 128'(mon_act), 128'(mon_req));
      end
    end
    if (nRST && (ld_valid != 4'b0000)) begin
      if (ld_q.size() == 0) begin
        chk("ld_unexpected", 128'(ld_valid), 128'd0);
      end else begin
        mon_ld   = ld_q.pop_front();
        mon_data = 128'd0;
        for (int l = 0; l < NL; l++) begin
          if (mon_ld.vmask[l]) mon_data[l*32 +: 32] = ld_data[l*32 +: 32];
        end
        chk("ld_valid", 128'(ld_valid), 128'(mon_ld.vmask));
        chk("ld_data", mon_data, mon_ld.data);
      end
    end
  end

  task automatic run_op(input logic st, input logic [1:0] md, input logic [4:0] uop,
                        input logic [31:0] b, input logic [31:0] strd, input logic [1:0] ew,
                        input logic [3:0] msk, input logic [127:0] idx, input logic [127:0] wd,
                        input int exp_done, input string name);
    int  c;
    bit  got;
    c   = 0;
    got = 1'b0;
    @(negedge CLK);
    is_store   = st;
    mode       = md;
    uop_num    = uop;
    base       = b;
    stride     = strd;
    veew       = ew;
    lane_mask  = msk;
    lane_index = idx;
    lane_wdata = wd;
    start      = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    while (c < 50 && !got) begin
      @(negedge CLK);
      c++;
      if (done) got = 1'b1;
    end
    if (!got) chk({name, "_timeout"}, 128'(c), 128'(exp_done));
    else      chk(name, 128'(c), 128'(exp_done));
  endtask

  initial begin
    logic [127:0] d;
    int           c;
    nRST       = 1'b0;
    start      = 1'b0;
    is_store   = 1'b0;
    mode       = 2'b00;
    uop_num    = 5'd0;
    base       = 32'h0;
    stride     = 32'h0;
    veew       = 2'b00;
    lane_mask  = 4'b0000;
    lane_index = 128'h0;
    lane_wdata = 128'h0;
    lsc_ready  = 1'b1;
    #12;
    chk("reset_outs", {lsc_ren, lsc_wen, lsc_addr, lsc_byte_en, lsc_wdata, cur_lane,
                       ld_valid, busy, done, misalign}, 128'd0);
    chk("reset_ld_data", ld_data, 128'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Unit-stride 32b load, uop 1: elements 4..7.
    d = 128'd0;
    for (int l = 0; l < NL; l++) begin
      push_req(1'b1, 1'b0, 32'h1010 + 32'(4 * l), 4'hF, 32'h0, 2'(l));
      d = 128'd0;
      d[l*32 +: 32] = 32'hC0DE_1010 + 32'(4 * l);
      push_ld(4'b0001 << l, d);
    end
    run_op(1'b0, 2'b00, 5'd1, 32'h1000, 32'h0, 2'b10, 4'b1111, 128'h0, 128'h0, 5, "unit_done");

    // Strided 16b store, stride -8, lanes 1 and 3 active.
    push_req(1'b0, 1'b1, 32'h1FF8, 4'b0011, 32'h0000_ABCD, 2'd1);
    push_req(1'b0, 1'b1, 32'h1FE8, 4'b0011, 32'h0000_BEEF, 2'd3);
    run_op(1'b1, 2'b01, 5'd0, 32'h2000, 32'hFFFF_FFF8, 2'b01, 4'b1010, 128'h0,
           {32'h2222_BEEF, 32'h3333_4444, 32'h1111_ABCD, 32'h5555_6666}, 3, "strided_done");
    chk("strided_no_misalign", 128'(misalign), 128'd0);

    // Indexed 32b load; lane 3 offset 3 is misaligned and skipped.
    push_req(1'b1, 1'b0, 32'h4000, 4'hF, 32'h0, 2'd0);
    push_req(1'b1, 1'b0, 32'h4004, 4'hF, 32'h0, 2'd1);
    push_req(1'b1, 1'b0, 32'h4040, 4'hF, 32'h0, 2'd2);
    push_ld(4'b0001, {96'h0, 32'hC0DE_4000});
    push_ld(4'b0010, {64'h0, 32'hC0DE_4004, 32'h0});
    push_ld(4'b0100, {32'h0, 32'hC0DE_4040, 64'h0});
    run_op(1'b0, 2'b10, 5'd0, 32'h4000, 32'h0, 2'b10, 4'b1111,
           {32'h3, 32'h40, 32'h4, 32'h0}, 128'h0, 4, "indexed_done");
    chk("indexed_misalign", 128'(misalign), 128'd1);

    // No active lane: straight to DONE, misalign cleared by the new start.
    run_op(1'b0, 2'b00, 5'd0, 32'h8000, 32'h0, 2'b10, 4'b0000, 128'h0, 128'h0, 1, "mask0_done");
    chk("mask0_misalign_clr", 128'(misalign), 128'd0);

    // 8b unit-stride load, base 0x3000: bytes of word 0xC0DE3000 are 00,30,DE,C0.
`ifdef RV32V_MEM_COALESCE_EN
    push_req(1'b1, 1'b0, 32'h3000, 4'b1111, 32'h0, 2'd0);
    push_ld(4'b1111, {32'hC0, 32'hDE, 32'h30, 32'h00});
    run_op(1'b0, 2'b00, 5'd0, 32'h3000, 32'h0, 2'b00, 4'b1111, 128'h0, 128'h0, 2, "byte_done");
`else
    push_req(1'b1, 1'b0, 32'h3000, 4'b0001, 32'h0, 2'd0);
    push_req(1'b1, 1'b0, 32'h3000, 4'b0010, 32'h0, 2'd1);
    push_req(1'b1, 1'b0, 32'h3000, 4'b0100, 32'h0, 2'd2);
    push_req(1'b1, 1'b0, 32'h3000, 4'b1000, 32'h0, 2'd3);
    push_ld(4'b0001, {96'h0, 32'h00});
    push_ld(4'b0010, {64'h0, 32'h30, 32'h0});
    push_ld(4'b0100, {32'h0, 32'hDE, 64'h0});
    push_ld(4'b1000, {32'hC0, 96'h0});
    run_op(1'b0, 2'b00, 5'd0, 32'h3000, 32'h0, 2'b00, 4'b1111, 128'h0, 128'h0, 5, "byte_done");
`endif

    // Stalled load, then asynchronous reset in the middle of the stall.
    lsc_ready = 1'b0;
    @(negedge CLK);
    is_store  = 1'b0;
    mode      = 2'b00;
    uop_num   = 5'd0;
    base      = 32'h5000;
    veew      = 2'b10;
    lane_mask = 4'b0001;
    start     = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (3) @(negedge CLK);
    chk("stall_req", {lsc_ren, lsc_wen, busy, lsc_addr}, {1'b1, 1'b0, 1'b1, 32'h5000});
    #1 nRST = 1'b0;
    #1 chk("rst_mid_outs", {lsc_ren, lsc_wen, busy, done, lsc_addr, lsc_byte_en}, 128'd0);
    @(negedge CLK);
    nRST      = 1'b1;
    lsc_ready = 1'b1;
    c = 0;
    repeat (3) begin
      @(negedge CLK);
      if (done || busy || lsc_ren) c++;
    end
    chk("rst_idle_after", 128'(c), 128'd0);

    // Recovery: single-lane 32b store works normally.
    push_req(1'b0, 1'b1, 32'h6000, 4'hF, 32'hDEAD_BEEF, 2'd0);
    run_op(1'b1, 2'b00, 5'd0, 32'h6000, 32'h0, 2'b10, 4'b0001, 128'h0,
           {96'h0, 32'hDEAD_BEEF}, 2, "recover_done");

    repeat (3) @(negedge CLK);
    chk("req_queue_empty", 128'(req_q.size()), 128'd0);
    chk("ld_queue_empty", 128'(ld_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
